// File: rtl/max_reduce_uint64.sv
// max_reduce_uint64: streaming unsigned max/argmax/count reduction over a valid/ready packet
module gt_uint_nbit #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt
);
  assign gt = a > b;
endmodule

module max_reduce_uint64 #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] run_max, max_nx;
  logic [IDX_W-1:0] run_idx, idx_nx, cnt, cnt_nx;
  logic run_ovf, ovf_nx, gt, first, sat, xfer_in;
  gt_uint_nbit #(.N(WIDTH)) u_gt (.a(in_data), .b(run_max), .gt(gt));
  assign in_ready = state != DONE;
  assign xfer_in = in_valid & in_ready;
  assign first = state == IDLE;
  assign sat = &cnt;
  always_comb begin
    max_nx = first || gt ? in_data : run_max;
    idx_nx = first ? '0 : gt ? cnt : run_idx;
    cnt_nx = first ? IDX_W'(1) : sat ? cnt : cnt + IDX_W'(1);
    ovf_nx = !first && (run_ovf || sat);
    state_nx = state == DONE ? (out_ready ? IDLE : DONE)
             : xfer_in ? (in_last ? DONE : ACCUM) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      run_max <= '0;
      run_idx <= '0;
      cnt <= '0;
      run_ovf <= 1'b0;
      out_valid <= 1'b0;
      out_max <= '0;
      out_idx <= '0;
      out_count <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      out_valid <= state_nx == DONE;
      if (xfer_in) begin
        run_max <= max_nx;
        run_idx <= idx_nx;
        cnt <= cnt_nx;
        run_ovf <= ovf_nx;
      end
      if (xfer_in && in_last) begin
        out_max <= max_nx;
        out_idx <= idx_nx;
        out_count <= cnt_nx;
        out_ovf <= ovf_nx;
      end
    end
  end
endmodule

// File: doc/max_reduce_uint64.md
Name: max_reduce_uint64

Overview:
- Streaming max-reduction stage that sits directly downstream of the pairwise unsigned max block.
- Consumes a packet of WIDTH-bit unsigned elements over a valid/ready stream, one element per cycle.
- Keeps a registered running maximum and its element index.
- Emits max, argmax and element count on a held output handshake after the packet's last element.
- Comparison uses gt_uint_nbit (strict A > B) against the registered running max.

Parameters:
- WIDTH, 64, element and result width in bits (unsigned).
- IDX_W, 16, width of the index and count fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  block can accept an element this cycle.
- in_data  input  WIDTH  unsigned input element.
- in_last  input  1  marks the final element of the packet; qualified by in_valid.
- out_valid  output  1  reduction result valid.
- out_ready  input  1  downstream accepts the result.
- out_max  output  WIDTH  maximum element of the packet.
- out_idx  output  IDX_W  zero-based index of the first occurrence of the maximum.
- out_count  output  IDX_W  number of elements accepted, saturating.
- out_ovf  output  1  packet contained more than 2^IDX_W-1 elements.

Behaviour:
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- States: IDLE, ACCUM, DONE. State and all outputs are registered.
- Reset (rst=1 at a clock edge), regardless of current state:
  - state=IDLE.
  - out_valid=0, out_max=0, out_idx=0, out_count=0, out_ovf=0.
  - Internal running max, index counter and overflow flag cleared.
  - Reset mid-packet or mid-hold discards all partial and held results.
- in_ready is combinational from state: 1 in IDLE and ACCUM, 0 in DONE.
- IDLE, on input transfer:
  - Running max = in_data, argmax = 0, count = 1.
  - If in_last=1, go to DONE; otherwise go to ACCUM.
- ACCUM, on input transfer:
  - If in_data > running max (strict unsigned), running max = in_data and argmax = current count value.
  - Count increments.
  - If in_last=1, go to DONE.
  - With no transfer, all state holds.
- Ties: equal values never replace the running max, so out_idx is the earliest occurrence.
- Count saturation:
  - Count saturates at 2^IDX_W-1.
  - Any accepted element while count is already saturated sets the overflow flag.
  - Argmax updates beyond the saturation point record the saturated value 2^IDX_W-1.
- Entering DONE:
  - The cycle after the in_last transfer, out_valid=1.
  - out_max, out_idx, out_count and out_ovf reflect the final element included.
  - Latency is 1 cycle from the last input transfer to out_valid.
- DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On output transfer: next cycle state=IDLE and out_valid=0. Data outputs keep their last values until the next result.
- No overlap: in_ready=0 throughout DONE, including the cycle of the output transfer. The next packet's first element is accepted no earlier than the cycle after the output transfer.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- A single-element packet (first transfer has in_last=1) yields out_max=in_data, out_idx=0, out_count=1.

Test Plan:
- Reset then packet 5, 9, 3 (last), out_ready=1 -> one cycle after the last transfer: out_valid=1, out_max=9, out_idx=1, out_count=3, out_ovf=0.
- Packet 0xFFFFFFFFFFFFFFFF, 7, 0xFFFFFFFFFFFFFFFF (last) -> out_max=0xFFFFFFFFFFFFFFFF, out_idx=0 (tie keeps first occurrence), out_count=3. Also check 0x8000000000000000 > 0x7FFFFFFFFFFFFFFF, i.e. the comparison is unsigned.
- Single element 42 with in_last=1, out_ready held 0 for 5 cycles -> out_valid=1 and outputs stable for all 5 cycles, in_ready=0 throughout. Raising out_ready -> out_valid=0 and in_ready=1 the next cycle.
- Packet 1, 2, 3, 4 (last) with in_valid gaps between elements and in_valid asserted during DONE -> idle cycles are ignored and the DONE-phase element is not consumed; result out_max=4, out_idx=3, out_count=4.
- rst asserted after 2 of 4 elements, then a fresh packet 10, 20 (last) -> result out_max=20, out_idx=1, out_count=2; no leftover state from the aborted packet.
- IDX_W=2, packet of 5 elements 1, 1, 1, 1, 9 (last) -> out_count=3, out_ovf=1, out_max=9, out_idx=3 (saturated).
